// File: rtl/time_field_setter_if.sv
// Key/edit bus of the time field setter: the debounced keys, mode and preload
// controls going in, and the edited field values, selection and change pulse
// coming out.
interface time_field_setter_if #(
    parameter int NUM_FIELDS = 3,
    parameter int FIELD_W    = 7
);
    localparam int SEL_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    logic [3:0]                    KEY;
    logic                          set_en;
    logic                          load;
    logic [NUM_FIELDS*FIELD_W-1:0] load_value;
    logic [NUM_FIELDS*FIELD_W-1:0] fields;
    logic [SEL_W-1:0]              sel;
    logic                          changed;

    modport master (
        output KEY, set_en, load, load_value,
        input  fields, sel, changed
    );

    modport slave (
        input  KEY, set_en, load, load_value,
        output fields, sel, changed
    );
endinterface

// File: rtl/time_field_setter.sv
// Time field editor: NUM_FIELDS binary fields, each wrapping at its own
// maximum. Inc/dec keys step once on press and auto-repeat after a hold;
// select keys move the edit cursor one field per press. A preload strobe
// copies the running time in, clamped to each field's maximum.
module time_field_setter #(
    parameter int                              NUM_FIELDS    = 3,
    parameter int                              FIELD_W       = 7,
    parameter logic [NUM_FIELDS*FIELD_W-1:0]   FIELD_MAX     = {7'd23, 7'd59, 7'd59},
    parameter int                              HOLD_CYCLES   = 1000000,
    parameter int                              REPEAT_CYCLES = 200000
) (
    input logic                CLK,
    input logic                RESETN,
    time_field_setter_if.slave bus
);
    localparam int SEL_W   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] K_INC  = 4'b1000;
    localparam logic [3:0] K_DEC  = 4'b0100;
    localparam logic [3:0] K_NEXT = 4'b0010;
    localparam logic [3:0] K_PREV = 4'b0001;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_FIELDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_REPEAT} state_t;

    state_t                        r_state;
    logic [3:0]                    r_key;
    logic [CNT_W-1:0]              r_cnt;
    logic [NUM_FIELDS*FIELD_W-1:0] r_fields;
    logic [SEL_W-1:0]              r_sel;
    logic                          r_changed;

    state_t                        w_next_state;
    logic [CNT_W-1:0]              w_next_cnt;
    logic [3:0]                    w_act;
    logic                          w_latch;
    logic                          w_step_key;
    logic [FIELD_W-1:0]            w_cur;
    logic [FIELD_W-1:0]            w_max;
    logic [NUM_FIELDS*FIELD_W-1:0] w_load_fields;

    // Increment with wrap; anything at or above the maximum restarts at zero.
    function automatic logic [FIELD_W-1:0] f_inc(input logic [FIELD_W-1:0] v,
                                                 input logic [FIELD_W-1:0] m);
        return (v >= m) ? '0 : v + FIELD_W'(1);
    endfunction

    // Decrement with wrap; zero or an out-of-range value lands on the maximum.
    function automatic logic [FIELD_W-1:0] f_dec(input logic [FIELD_W-1:0] v,
                                                 input logic [FIELD_W-1:0] m);
        return ((v == '0) || (v > m)) ? m : v - FIELD_W'(1);
    endfunction

    // Saturate a preloaded value to the field maximum.
    function automatic logic [FIELD_W-1:0] f_clamp(input logic [FIELD_W-1:0] v,
                                                   input logic [FIELD_W-1:0] m);
        return (v > m) ? m : v;
    endfunction

    assign w_step_key = r_key[3] | r_key[2];
    assign w_cur      = r_fields[int'(r_sel)*FIELD_W +: FIELD_W];
    assign w_max      = FIELD_MAX[int'(r_sel)*FIELD_W +: FIELD_W];

    // Key tracking: decide whether this edge performs an action and where the FSM goes.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_act        = 4'b0000;
        w_latch      = 1'b0;
        if (!bus.set_en) begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ($onehot(bus.KEY)) begin
                        w_act        = bus.KEY;
                        w_latch      = 1'b1;
                        w_next_state = S_PRESS;
                        w_next_cnt   = '0;
                    end
                end
                S_PRESS: begin
                    if (bus.KEY != r_key) begin
                        w_next_state = S_IDLE;
                        w_next_cnt   = '0;
                    end else if (w_step_key) begin
                        // Select keys never repeat, so their counter stays parked at zero.
                        if (r_cnt == HOLD_LAST) begin
                            w_act        = r_key;
                            w_next_cnt   = '0;
                            w_next_state = S_REPEAT;
                        end else begin
                            w_next_cnt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_REPEAT: begin
                    if (bus.KEY != r_key) begin
                        w_next_state = S_IDLE;
                        w_next_cnt   = '0;
                    end else if (r_cnt == REPEAT_LAST) begin
                        w_act      = r_key;
                        w_next_cnt = '0;
                    end else begin
                        w_next_cnt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    // Preload image: every field clamped to its own maximum.
    always_comb begin
        w_load_fields = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            w_load_fields[i*FIELD_W +: FIELD_W] =
                f_clamp(bus.load_value[i*FIELD_W +: FIELD_W], FIELD_MAX[i*FIELD_W +: FIELD_W]);
        end
    end

    // State, counter and field registers; a preload wins over any key action on the same edge.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state   <= S_IDLE;
            r_key     <= 4'b0000;
            r_cnt     <= '0;
            r_fields  <= '0;
            r_sel     <= '0;
            r_changed <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_changed <= 1'b0;
            if (w_latch) begin
                r_key <= bus.KEY;
            end
            if (bus.load) begin
                r_fields <= w_load_fields;
            end else begin
                case (w_act)
                    K_INC: begin
                        r_fields[int'(r_sel)*FIELD_W +: FIELD_W] <= f_inc(w_cur, w_max);
                        r_changed <= 1'b1;
                    end
                    K_DEC: begin
                        r_fields[int'(r_sel)*FIELD_W +: FIELD_W] <= f_dec(w_cur, w_max);
                        r_changed <= 1'b1;
                    end
                    K_NEXT: r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + SEL_W'(1);
                    K_PREV: r_sel <= (r_sel == '0) ? SEL_LAST : r_sel - SEL_W'(1);
                    default: ;
                endcase
            end
        end
    end

    assign bus.fields  = r_fields;
    assign bus.sel     = r_sel;
    assign bus.changed = r_changed;
endmodule

// File: tb/tb_time_field_setter.sv
// Bench for time_field_setter with short hold/repeat intervals: directed
// scenarios with literal expectations, then randomized key/preload/mode
// traffic compared every cycle against a press-duration reference model.
module tb_time_field_setter;
    localparam int NF   = 3;
    localparam int FW   = 7;
    localparam int HOLD = 10;
    localparam int REP  = 4;
    localparam logic [NF*FW-1:0] FMAX = {7'd23, 7'd59, 7'd59};

    logic CLK    = 1'b0;
    logic RESETN = 1'b0;

    always #5 CLK = ~CLK;

    time_field_setter_if #(.NUM_FIELDS(NF), .FIELD_W(FW)) bus();

    time_field_setter #(
        .NUM_FIELDS(NF), .FIELD_W(FW), .FIELD_MAX(FMAX),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .CLK(CLK),
        .RESETN(RESETN),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks how many edges the current key has been held.
    int         mmax[NF] = '{59, 59, 23};
    int         mf[NF]   = '{0, 0, 0};
    int         msel     = 0;
    bit         mchg     = 1'b0;
    bit         mact     = 1'b0;
    logic [3:0] mheld    = 4'b0;
    logic [3:0] ma;
    int         mn       = 0;
    int         lv;

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < NF; i++) mf[i] = 0;
            msel = 0; mchg = 1'b0; mact = 1'b0; mheld = 4'b0; mn = 0;
        end else begin
            ma   = 4'b0;
            mchg = 1'b0;
            if (!bus.set_en) begin
                mact = 1'b0;
            end else if (!mact) begin
                if ($onehot(bus.KEY)) begin
                    mact = 1'b1; mheld = bus.KEY; mn = 0; ma = bus.KEY;
                end
            end else if (bus.KEY != mheld) begin
                mact = 1'b0;
            end else begin
                mn++;
                if ((mheld[3] || mheld[2]) && mn >= HOLD && ((mn - HOLD) % REP) == 0)
                    ma = mheld;
            end
            if (bus.load) begin
                for (int i = 0; i < NF; i++) begin
                    lv = int'(bus.load_value[i*FW +: FW]);
                    mf[i] = (lv > mmax[i]) ? mmax[i] : lv;
                end
            end else if (ma == 4'b1000) begin
                mf[msel] = (mf[msel] >= mmax[msel]) ? 0 : mf[msel] + 1;
                mchg = 1'b1;
            end else if (ma == 4'b0100) begin
                mf[msel] = (mf[msel] == 0 || mf[msel] > mmax[msel]) ? mmax[msel] : mf[msel] - 1;
                mchg = 1'b1;
            end else if (ma == 4'b0010) begin
                msel = (msel + 1) % NF;
            end else if (ma == 4'b0001) begin
                msel = (msel + NF - 1) % NF;
            end
        end
    end

    logic [NF*FW-1:0] exp_vec;

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (RESETN) begin
            for (int i = 0; i < NF; i++) exp_vec[i*FW +: FW] = FW'(mf[i]);
            check("model_fields", 32'(bus.fields), 32'(exp_vec));
            check("model_sel", 32'(bus.sel), msel);
            check("model_changed", 32'(bus.changed), 32'(mchg));
            if (bus.changed) pulses++;
        end
    end

    function automatic int fld(input int i);
        return int'(bus.fields[i*FW +: FW]);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        bus.KEY = 4'b0; bus.load = 1'b0; bus.set_en = 1'b1;
        step(2);
        RESETN = 1'b1;
        step(1);
    endtask

    task automatic tap(input logic [3:0] k);
        bus.KEY = k;
        step(1);
        bus.KEY = 4'b0;
        step(1);
    endtask

    int hv[20];
    int p0;
    int left;
    logic [3:0] inv_keys[5] = '{4'b1100, 4'b0011, 4'b1010, 4'b0111, 4'b1111};

    initial begin
        bus.KEY = 4'b0; bus.set_en = 1'b1; bus.load = 1'b0; bus.load_value = '0;
        step(2);
        check("reset_fields", 32'(bus.fields), 0);
        check("reset_sel", 32'(bus.sel), 0);
        check("reset_changed", 32'(bus.changed), 0);
        RESETN = 1'b1;
        step(1);

        // Short tap: one step, no repeat.
        p0 = pulses;
        bus.KEY = 4'b1000; step(3); bus.KEY = 4'b0; step(3);
        check("tap_field0", fld(0), 1);
        check("tap_pulses", pulses - p0, 1);

        // Hold: press step, then hold interval, then repeat interval.
        do_reset();
        p0 = pulses;
        bus.KEY = 4'b1000;
        for (int k = 0; k < 20; k++) begin
            step(1);
            hv[k] = fld(0);
        end
        bus.KEY = 4'b0; step(2);
        check("hold_t0", hv[0], 1);
        check("hold_t9", hv[9], 1);
        check("hold_t10", hv[10], 2);
        check("hold_t13", hv[13], 2);
        check("hold_t14", hv[14], 3);
        check("hold_t18", hv[18], 4);
        check("hold_t19", hv[19], 4);
        check("hold_pulses", pulses - p0, 4);

        // Field select: no repeat, wraps both ways.
        do_reset();
        bus.KEY = 4'b0010; step(15); bus.KEY = 4'b0; step(1);
        check("sel_norepeat", 32'(bus.sel), 1);
        tap(4'b0010);
        check("sel_two", 32'(bus.sel), 2);
        bus.KEY = 4'b0100; step(1);
        check("dec_wrap_f2", fld(2), 23);
        step(10);
        check("dec_repeat_f2", fld(2), 22);
        bus.KEY = 4'b0; step(1);
        tap(4'b0010);
        check("sel_wrap_next", 32'(bus.sel), 0);
        tap(4'b0001);
        check("sel_wrap_prev", 32'(bus.sel), 2);

        // Preload clamps and never pulses changed.
        p0 = pulses;
        bus.load_value = {7'd30, 7'd70, 7'd5}; bus.load = 1'b1; step(1); bus.load = 1'b0; step(2);
        check("load_fields", 32'(bus.fields), 32'({7'd23, 7'd59, 7'd5}));
        check("load_nochg", pulses - p0, 0);
        check("load_sel", 32'(bus.sel), 2);
        tap(4'b1000);
        check("inc_wrap_f2", fld(2), 0);
        tap(4'b0010); tap(4'b0010);
        tap(4'b1000);
        check("inc_wrap_f1", fld(1), 0);

        // Key switch without release, then an invalid two-key pattern.
        do_reset();
        bus.KEY = 4'b1000; step(3);
        check("sw_inc", fld(0), 1);
        bus.KEY = 4'b0100; step(1);
        check("sw_idle_edge", fld(0), 1);
        step(1);
        check("sw_dec", fld(0), 0);
        bus.KEY = 4'b1100; step(15);
        check("sw_invalid", fld(0), 0);
        bus.KEY = 4'b0; step(1);

        // Preload on a press edge discards the action but the hold timing continues.
        do_reset();
        bus.load_value = {7'd0, 7'd0, 7'd5}; bus.load = 1'b1; bus.KEY = 4'b1000;
        step(1);
        bus.load = 1'b0;
        check("load_key_discard", fld(0), 5);
        step(10);
        check("load_key_hold", fld(0), 6);
        bus.KEY = 4'b0; step(1);

        // set_en low freezes stepping; raising it with the key held is a fresh press.
        do_reset();
        bus.KEY = 4'b1000; step(14);
        check("en_before", fld(0), 2);
        bus.set_en = 1'b0; step(10);
        check("en_hold", fld(0), 2);
        bus.set_en = 1'b1; step(1);
        check("en_fresh", fld(0), 3);
        step(1);
        check("en_single", fld(0), 3);

        // Asynchronous reset in the middle of a hold.
        step(10);
        RESETN = 1'b0; #1;
        check("async_fields", 32'(bus.fields), 0);
        check("async_sel", 32'(bus.sel), 0);
        check("async_changed", 32'(bus.changed), 0);
        step(2);
        RESETN = 1'b1; step(1);
        check("post_reset_press", fld(0), 1);
        bus.KEY = 4'b0; step(2);

        // Randomized traffic checked by the per-cycle model compare.
        left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (left == 0) begin
                case ($urandom_range(0, 9))
                    0: bus.KEY = 4'b0;
                    1: bus.KEY = inv_keys[$urandom_range(0, 4)];
                    default: bus.KEY = 4'b0001 << $urandom_range(0, 3);
                endcase
                left = $urandom_range(1, 30);
            end
            left--;
            bus.set_en     = ($urandom_range(0, 29) != 0);
            bus.load       = ($urandom_range(0, 39) == 0);
            bus.load_value = (NF*FW)'($urandom);
            step(1);
        end
        bus.KEY = 4'b0; bus.load = 1'b0; step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
